cache_ctrl_param: RTL and testbench

CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

---
 rtl/cache_ctrl_param.sv | 236 +++++++++++++++++++++++
 tb/tb_cache_ctrl_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_param.sv
// Parameterised write-back, write-allocate cache controller (1- or 2-way, LRU)
// with a single full-line memory port and IDLE / WRITEBACK / REFILL sequencing.
module cache_ctrl_param #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned SETS        = 4,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              read_CPU,
  input  logic                              write_CPU,
  input  logic                              Bytesel,
  input  logic [ADDR_W-1:0]                 Addr_CPU,
  input  logic [WORD_SIZE-1:0]              Data_in,
  output logic [WORD_SIZE-1:0]              Data_out,
  output logic                              Ack,
  output logic                              Stall_PC,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0]  mem_wdata,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0]  mem_rdata,
  input  logic                              mem_ready
);

  localparam int unsigned LINE_W   = WORD_SIZE * BLOCK_WORDS;
  localparam int unsigned BYTE_OFF = $clog2(WORD_SIZE / 8);
  localparam int unsigned WORD_OFF = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF_W    = BYTE_OFF + WORD_OFF;
  localparam int unsigned IDX_W    = $clog2(SETS);
  localparam int unsigned TAG_W    = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LBIT_W   = OFF_W + 3;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state_q, state_d;

  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [SETS-1:0]   lru_q;

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 bsel_q, bsel_d, wr_q, wr_d, victim_q, victim_d;

  logic [WORD_SIZE-1:0] data_out_d;
  logic                 ack_d, stall_d, mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_d;
  logic [LINE_W-1:0]    mem_wdata_d;

  // Current access: CPU inputs while idle, latched request during a miss
  logic                 idle, cur_wr, cur_bsel;
  logic [ADDR_W-1:0]    cur_addr, block_addr;
  logic [WORD_SIZE-1:0] cur_wdata;
  logic [TAG_W-1:0]     cur_tag;
  logic [IDX_W-1:0]     cur_idx;
  logic [LBIT_W-1:0]    word_lo, byte_lo;

  assign idle       = (state_q == IDLE);
  assign cur_addr   = idle ? Addr_CPU  : addr_q;
  assign cur_wdata  = idle ? Data_in   : wdata_q;
  assign cur_bsel   = idle ? Bytesel   : bsel_q;
  assign cur_wr     = idle ? write_CPU : wr_q;
  assign cur_tag    = cur_addr[ADDR_W-1 -: TAG_W];
  assign cur_idx    = cur_addr[OFF_W +: IDX_W];
  assign word_lo    = {cur_addr[OFF_W-1:BYTE_OFF], {(BYTE_OFF+3){1'b0}}};
  assign byte_lo    = {cur_addr[OFF_W-1:0], 3'b000};
  assign block_addr = {cur_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  logic                 hit, hit_way, victim, way_w;
  logic [LINE_W-1:0]    base_line, merged_line, arr_line;
  logic [WORD_SIZE-1:0] rd_val;

  // Tag lookup, victim choice (invalid way first, else LRU) and data merge
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    way_w   = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      way_w = 1'(w);
      if (valid_q[cur_idx][way_w] && (tag_q[way_w][cur_idx] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = way_w;
      end
    end
    if (!valid_q[cur_idx][0])
      victim = 1'b0;
    else if (WAYS > 1 && !valid_q[cur_idx][1'(WAYS-1)])
      victim = 1'b1;
    else
      victim = (WAYS > 1) ? lru_q[cur_idx] : 1'b0;

    base_line   = idle ? data_q[hit_way][cur_idx] : mem_rdata;
    merged_line = base_line;
    if (cur_bsel) merged_line[byte_lo +: 8]         = cur_wdata[7:0];
    else          merged_line[word_lo +: WORD_SIZE] = cur_wdata;
    arr_line = cur_wr ? merged_line : base_line;
    rd_val   = cur_bsel ? WORD_SIZE'(base_line[byte_lo +: 8])
                        : base_line[word_lo +: WORD_SIZE];
  end

  logic arr_way, line_we, fill, touch;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    data_out_d  = Data_out;
    ack_d       = 1'b0;
    stall_d     = Stall_PC;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bsel_d      = bsel_q;
    wr_d        = wr_q;
    victim_d    = victim_q;
    arr_way     = hit_way;
    line_we     = 1'b0;
    fill        = 1'b0;
    touch       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_CPU || write_CPU) begin
          if (hit) begin
            touch = 1'b1;
            ack_d = 1'b1;
            if (write_CPU) line_we    = 1'b1;
            else           data_out_d = rd_val;
          end else begin
            addr_d    = Addr_CPU;
            wdata_d   = Data_in;
            bsel_d    = Bytesel;
            wr_d      = write_CPU;
            victim_d  = victim;
            stall_d   = 1'b1;
            mem_req_d = 1'b1;
            if (valid_q[cur_idx][victim] && dirty_q[cur_idx][victim]) begin
              state_d     = WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {tag_q[victim][cur_idx], cur_idx, {OFF_W{1'b0}}};
              mem_wdata_d = data_q[victim][cur_idx];
            end else begin
              state_d    = REFILL;
              mem_we_d   = 1'b0;
              mem_addr_d = block_addr;
            end
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_d    = REFILL;
          mem_we_d   = 1'b0;
          mem_addr_d = block_addr;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          arr_way   = victim_q;
          line_we   = 1'b1;
          fill      = 1'b1;
          touch     = 1'b1;
          ack_d     = 1'b1;
          stall_d   = 1'b0;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!wr_q) data_out_d = rd_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      Data_out  <= '0;
      Ack       <= 1'b0;
      Stall_PC  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bsel_q    <= 1'b0;
      wr_q      <= 1'b0;
      victim_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      Data_out  <= data_out_d;
      Ack       <= ack_d;
      Stall_PC  <= stall_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bsel_q    <= bsel_d;
      wr_q      <= wr_d;
      victim_q  <= victim_d;
    end
  end

  // Line status: a fill installs clean unless the pending access was a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (fill) begin
        valid_q[cur_idx][arr_way] <= 1'b1;
        dirty_q[cur_idx][arr_way] <= cur_wr;
      end else if (line_we) begin
        dirty_q[cur_idx][arr_way] <= 1'b1;
      end
      if (touch && WAYS > 1) lru_q[cur_idx] <= ~arr_way;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) data_q[arr_way][cur_idx] <= arr_line;
    if (fill)    tag_q[arr_way][cur_idx]  <= cur_tag;
  end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Directed bench for cache_ctrl_param: zero-filled line memory answering
// 3 cycles after mem_req, hand-computed hit/miss/writeback expectations.
module tb_cache_ctrl_param;

  logic         clk = 1'b0;
  logic         reset;
  logic         read_CPU, write_CPU, Bytesel;
  logic [31:0]  Addr_CPU, Data_in, Data_out;
  logic         Ack, Stall_PC, mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  cache_ctrl_param dut (
    .clk       (clk),
    .reset     (reset),
    .read_CPU  (read_CPU),
    .write_CPU (write_CPU),
    .Bytesel   (Bytesel),
    .Addr_CPU  (Addr_CPU),
    .Data_in   (Data_in),
    .Data_out  (Data_out),
    .Ack       (Ack),
    .Stall_PC  (Stall_PC),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line memory model; writebacks are stored so later refills see them
  logic [127:0] mem_model [1024];
  int           rf_count = 0, wb_count = 0, req_cycles = 0, mcnt = 0;
  logic [31:0]  rf_addr = '0, wb_addr = '0;
  logic [127:0] wb_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      mem_ready = 1'b0;
      mcnt      = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      mcnt      = 0;
    end else if (mem_req) begin
      req_cycles++;
      mcnt++;
      if (mcnt == 3) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          wb_count++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
          mem_model[mem_addr[13:4]] = mem_wdata;
        end else begin
          rf_count++;
          rf_addr   = mem_addr;
          mem_rdata = mem_model[mem_addr[13:4]];
        end
      end
    end else begin
      mcnt = 0;
    end
  end

  // One CPU access: present for one edge, then wait (bounded) for Ack
  task automatic run(input logic rd, input logic wr, input logic bs,
                     input logic [31:0] a, input logic [31:0] d,
                     input int exp_rf, input int exp_wb,
                     input logic [31:0] exp_data, input logic chk_data,
                     input string name);
    int   s_rf, s_wb, s_req, n;
    logic stall_bad;
    s_rf  = rf_count;
    s_wb  = wb_count;
    s_req = req_cycles;
    read_CPU = rd; write_CPU = wr; Bytesel = bs; Addr_CPU = a; Data_in = d;
    @(posedge clk); #1;
    read_CPU = 1'b0; write_CPU = 1'b0;
    n = 0;
    stall_bad = 1'b0;
    while (!Ack && n < 40) begin
      if (!Stall_PC) stall_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({name, "_ack"}, Ack, 1'b1);
    check({name, "_stall_miss"}, stall_bad, 1'b0);
    check({name, "_stall_ack"}, Stall_PC, 1'b0);
    check({name, "_refills"}, 128'(rf_count - s_rf), 128'(exp_rf));
    check({name, "_writebacks"}, 128'(wb_count - s_wb), 128'(exp_wb));
    check({name, "_memreq_idle"}, req_cycles == s_req, (exp_rf + exp_wb) == 0);
    if (chk_data) check({name, "_data"}, Data_out, exp_data);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    reset = 1'b0;
    read_CPU = 1'b0; write_CPU = 1'b0; Bytesel = 1'b0;
    Addr_CPU = '0; Data_in = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", Ack, 1'b0);
    check("rst_stall", Stall_PC, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_data_out", Data_out, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 1'b1, 1'b0, 32'h4, 32'h55, 1, 0, 32'h0, 1'b0, "wr_4");
    check("wr_4_rf_addr", rf_addr, 32'h0);
    run(1'b1, 1'b0, 1'b1, 32'h1, 32'h0, 0, 0, 32'h0, 1'b1, "rdb_1");
    run(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 0, 0, 32'h55, 1'b1, "rd_4");
    run(1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 0, 0, 32'h55, 1'b1, "rdb_4");
    run(1'b0, 1'b1, 1'b1, 32'h6, 32'hDEADBEAB, 0, 0, 32'h0, 1'b0, "wrb_6");
    run(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 0, 0, 32'h00AB0055, 1'b1, "rd_4_merged");
    run(1'b1, 1'b0, 1'b1, 32'h6, 32'h0, 0, 0, 32'h000000AB, 1'b1, "rdb_6");
    run(1'b1, 1'b1, 1'b0, 32'h8, 32'h1234, 0, 0, 32'h0, 1'b0, "rdwr_8");
    run(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 0, 0, 32'h1234, 1'b1, "rd_8");

    run(1'b0, 1'b1, 1'b0, 32'hff0, 32'h77, 1, 0, 32'h0, 1'b0, "wr_ff0");
    check("wr_ff0_rf_addr", rf_addr, 32'hff0);
    run(1'b1, 1'b0, 1'b0, 32'h1ff0, 32'h0, 1, 0, 32'h0, 1'b1, "rd_1ff0");
    run(1'b1, 1'b0, 1'b0, 32'hff0, 32'h0, 0, 0, 32'h77, 1'b1, "rd_ff0_hit");
    run(1'b1, 1'b0, 1'b0, 32'h7f0, 32'h0, 1, 0, 32'h0, 1'b1, "rd_7f0");
    check("rd_7f0_rf_addr", rf_addr, 32'h7f0);
    run(1'b1, 1'b0, 1'b0, 32'h1ff0, 32'h0, 1, 1, 32'h0, 1'b1, "rd_1ff0_evict");
    check("evict_wb_addr", wb_addr, 32'hff0);
    check("evict_wb_word0", wb_data[31:0], 32'h77);
    check("evict_rf_addr", rf_addr, 32'h1ff0);
    run(1'b1, 1'b0, 1'b0, 32'hff0, 32'h0, 1, 0, 32'h77, 1'b1, "rd_ff0_refill");

    // Reset pulse in the middle of a refill
    read_CPU = 1'b1; Addr_CPU = 32'h3000;
    @(posedge clk); #1;
    read_CPU = 1'b0;
    check("midmiss_mem_req", mem_req, 1'b1);
    check("midmiss_stall", Stall_PC, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_mem_we", mem_we, 1'b0);
    check("midrst_stall", Stall_PC, 1'b0);
    check("midrst_ack", Ack, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    run(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 1, 0, 32'h0, 1'b1, "rd_3000_after_rst");
    run(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1, 0, 32'h0, 1'b1, "rd_4_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
